// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path:
// opcode values, immediate-format select, ALU operations, controller states.
package riscv_pkg;

   localparam int OPW  = 7;
   localparam int SELW = 3;

   localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPW-1:0] OP_R      = 7'b0110011;
   localparam logic [OPW-1:0] OP_I      = 7'b0010011;
   localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [SELW-1:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   // ALU_ADD is all-zero so an idle controller drives alu_ctrl = 0
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_ctrl_e;

   // coarse ALU intent from the FSM; the decoder refines FUNCT using funct fields
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_PASSB = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_UTYPE    = 4'd9,
      S_ALUWB    = 4'd10,
      S_JAL      = 4'd11,
      S_BRANCH   = 4'd12,
      S_ILLEGAL  = 4'd13
   } ctrl_state_e;

   // immediate format implied by the opcode (I format for anything without one)
   function automatic imm_src_e imm_sel(input logic [OPW-1:0] op);
      case (op)
         OP_STORE:         imm_sel = IMM_S;
         OP_BRANCH:        imm_sel = IMM_B;
         OP_JAL:           imm_sel = IMM_J;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         default:          imm_sel = IMM_I;
      endcase
   endfunction

   // branch condition from funct3 and ALU flags; unsupported funct3 never branches
   function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
      case (f3)
         3'b000:  branch_taken = z;
         3'b001:  branch_taken = ~z;
         3'b100:  branch_taken = l;
         3'b101:  branch_taken = ~l;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: turns the FSM's coarse ALU intent plus
// the instruction's funct fields into the concrete ALU operation.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  alu_op_e    alu_op,
   output alu_ctrl_e  alu_ctrl
);

   // select ALU operation; SUB only for register-register ops with funct7b5
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD:   alu_ctrl = ALU_ADD;
         ALUOP_SUB:   alu_ctrl = ALU_SUB;
         ALUOP_PASSB: alu_ctrl = ALU_PASSB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default:     alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Outputs are decoded from the
// current state (plus mem_ready / branch flags for the strobes that complete a
// step). Optional feature macro ILLEGAL_TRAP_EN: when defined, an unknown
// opcode parks the controller in ILLEGAL with illegal_inst=1 until reset;
// otherwise ILLEGAL is a one-cycle NOP and illegal_inst is tied low.
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  opcode,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic            zero,
   input  logic            lt,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            mem_we,
   output logic            adr_src,
   output logic            ir_write,
   output logic            pc_write,
   output logic            reg_write,
   output logic [1:0]      alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      result_src,
   output logic [3:0]      alu_ctrl,
   output logic [SELW-1:0] imm_src,
   output logic            illegal_inst
);

   ctrl_state_e state_q, state_d;
   alu_op_e     alu_op_s;
   alu_ctrl_e   alu_ctrl_s;

   // state register; asynchronous reset also drops any in-flight memory request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state and Moore strobe decode
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op_s   = ALUOP_ADD;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            if (opcode == OP_LOAD) state_d = S_MEMREAD;
            else                   state_d = S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
            else           state_d = S_MEMREAD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_FETCH;
            else           state_d = S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op_s  = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op_s  = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_UTYPE: begin
            // lui passes the immediate through; auipc adds it to the old PC
            alu_src_b = 2'b01;
            if (opcode == OP_LUI) begin
               alu_op_s = ALUOP_PASSB;
            end else begin
               alu_src_a = 2'b01;
            end
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target held in the ALU register; ALU forms the link
            pc_write  = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op_s  = ALUOP_SUB;
            pc_write  = branch_taken(funct3, zero, lt);
            state_d   = S_FETCH;
         end
         S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_ILLEGAL;
`else
            state_d = S_FETCH;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   alu_decoder u_alu_decoder (
      .op5      (opcode[5]),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .alu_op   (alu_op_s),
      .alu_ctrl (alu_ctrl_s)
   );

   assign alu_ctrl = alu_ctrl_s;
   // immediate format held for the whole instruction; forced to 0 while idle
   assign imm_src  = (state_q == S_IDLE) ? 3'b000 : imm_sel(opcode);

`ifdef ILLEGAL_TRAP_EN
   assign illegal_inst = (state_q == S_ILLEGAL);
`else
   assign illegal_inst = 1'b0;
`endif

endmodule
